debug_frame_tx: RTL and testbench

//  Periodic/on-demand debug telemetry framer; successor to the single-word debug streamer.

---
 rtl/debug_frame_tx_if.sv | 11 +
 rtl/debug_frame_tx.sv | 173 +++++++++++++++++
 tb/tb_debug_frame_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_tx_if.sv
// UART transmit handshake between the debug framer and an external uart_tx.
// The framer is the master: it issues tx_start/tx_data and observes tx_busy.
`timescale 1ns/1ps
interface debug_frame_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/debug_frame_tx.sv
// Debug telemetry framer: snapshots NUM_CHANNELS words and streams them to a UART
// as ASCII hex or raw bytes, separated by SEPARATOR and closed by TERMINATOR.
`timescale 1ns/1ps
module debug_frame_tx #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned CHANNEL_WIDTH = 16,
    parameter int unsigned PERIOD_WIDTH  = 28,
    parameter int unsigned PERIOD_TICKS  = 67000000,
    parameter int unsigned HEX_MODE      = 1,
    parameter logic [7:0]  SEPARATOR     = 8'h20,
    parameter logic [7:0]  TERMINATOR    = 8'h0A
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic                                  trigger,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] data_in,
    debug_frame_tx_if.master                      uart,
    output logic                                  frame_busy,
    output logic                                  frame_done,
    output logic                                  overrun
);
    localparam int SPC   = (HEX_MODE != 0) ? int'(CHANNEL_WIDTH / 4) : int'(CHANNEL_WIDTH / 8);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int SYM_W = $clog2(SPC + 1);
    localparam logic [PERIOD_WIDTH-1:0] PT_LAST  = PERIOD_WIDTH'(PERIOD_TICKS - 1);
    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [SYM_W-1:0]        SYM_SEP  = SYM_W'(SPC);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_LOAD, S_START, S_GUARD, S_WAIT, S_DONE
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h41 + {4'h0, n} - 8'h0A;
        end
    endfunction

    state_t                                state_q, state_d;
    logic [PERIOD_WIDTH-1:0]               cnt_q, cnt_d;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] snap_q, snap_d;
    logic [CH_W-1:0]                       ch_q, ch_d;
    logic [SYM_W-1:0]                      sym_q, sym_d;
    logic                                  tx_start_q, tx_start_d;
    logic [7:0]                            tx_data_q, tx_data_d;
    logic                                  frame_busy_q, frame_busy_d;
    logic                                  frame_done_q, frame_done_d;
    logic                                  overrun_q, overrun_d;
    logic                                  tick_s;
    logic                                  req_s;
    logic [CHANNEL_WIDTH-1:0]              ch_word_s;
    logic [7:0]                            symbol_s;

    // Period counter: runs only while enabled, wraps on the tick cycle.
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (PERIOD_TICKS == 32'd0) begin
            cnt_d = '0;
        end else if (cnt_q == PT_LAST) begin
            cnt_d  = '0;
            tick_s = 1'b1;
        end else begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
        req_s = tick_s | (trigger & enable);
    end

    // Current symbol: a digit/byte of the current channel, or the trailing delimiter.
    always_comb begin
        ch_word_s = CHANNEL_WIDTH'(snap_q >> (int'(ch_q) * int'(CHANNEL_WIDTH)));
        symbol_s  = 8'h00;
        if (sym_q == SYM_SEP) begin
            symbol_s = (ch_q == CH_LAST) ? TERMINATOR : SEPARATOR;
        end else if (HEX_MODE != 0) begin
            symbol_s = hex_ascii(4'(ch_word_s >> (4 * (SPC - 1 - int'(sym_q)))));
        end else begin
            symbol_s = 8'(ch_word_s >> (8 * (SPC - 1 - int'(sym_q))));
        end
    end

    // Frame sequencer next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ch_d      = ch_q;
        sym_d     = sym_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q | (req_s & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                snap_d  = data_in;
                ch_d    = '0;
                sym_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!uart.tx_busy) begin
                    tx_data_d = symbol_s;
                    state_d   = S_START;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_START: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (uart.tx_busy) begin
                    state_d = S_WAIT;
                end else if ((ch_q == CH_LAST) && (sym_q == SYM_SEP)) begin
                    state_d = S_DONE;
                end else if (sym_q == SYM_SEP) begin
                    sym_d   = '0;
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_LOAD;
                end else begin
                    sym_d   = sym_q + SYM_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        tx_start_d   = (state_d == S_START);
        frame_busy_d = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            snap_q       <= '0;
            ch_q         <= '0;
            sym_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            ch_q         <= ch_d;
            sym_q        <= sym_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign uart.tx_start = tx_start_q;
    assign uart.tx_data  = tx_data_q;
    assign frame_busy    = frame_busy_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench: a hex-mode instance driven by triggers and a raw-mode instance
// running off the period counter, each attached to a simple busy-counting UART model.
`timescale 1ns/1ps
module tb_debug_frame_tx;
    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        enable_a, trigger_a, enable_b, trigger_b;
    logic [15:0] data_a;
    logic [31:0] data_b;
    logic        frame_busy_a, frame_done_a, overrun_a;
    logic        frame_busy_b, frame_done_b, overrun_b;
    int          checks = 0;
    int          errors = 0;
    int          bcnt_a, bcnt_b;
    int          viol_a = 0, viol_b = 0, done_a = 0, done_b = 0, cyc = 0;
    logic        busy_prev_b = 1'b0;
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    int          starts_b[$];

    always #5 clk_in = ~clk_in;

    debug_frame_tx_if ifa ();
    debug_frame_tx_if ifb ();

    debug_frame_tx #(
        .NUM_CHANNELS(2), .CHANNEL_WIDTH(8), .PERIOD_WIDTH(8), .PERIOD_TICKS(0),
        .HEX_MODE(1), .SEPARATOR(8'h20), .TERMINATOR(8'h0A)
    ) dut_a (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable_a), .trigger(trigger_a),
        .data_in(data_a), .uart(ifa.master), .frame_busy(frame_busy_a),
        .frame_done(frame_done_a), .overrun(overrun_a)
    );

    debug_frame_tx #(
        .NUM_CHANNELS(2), .CHANNEL_WIDTH(16), .PERIOD_WIDTH(8), .PERIOD_TICKS(100),
        .HEX_MODE(0), .SEPARATOR(8'h20), .TERMINATOR(8'h0A)
    ) dut_b (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable_b), .trigger(trigger_b),
        .data_in(data_b), .uart(ifb.master), .frame_busy(frame_busy_b),
        .frame_done(frame_done_b), .overrun(overrun_b)
    );

    // UART models: busy for a fixed number of cycles after each tx_start.
    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_a <= 0;
            bcnt_b <= 0;
        end else begin
            if (ifa.tx_start) bcnt_a <= 3;
            else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
            if (ifb.tx_start) bcnt_b <= 8;
            else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
        end
    end
    assign ifa.tx_busy = (bcnt_a != 0);
    assign ifb.tx_busy = (bcnt_b != 0);

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitors: collect transmitted bytes, frame completions and frame start times.
    always @(negedge clk_in) begin
        if (ifa.tx_start) begin
            q_a.push_back(ifa.tx_data);
            if (ifa.tx_busy) viol_a <= viol_a + 1;
        end
        if (ifb.tx_start) begin
            q_b.push_back(ifb.tx_data);
            if (ifb.tx_busy) viol_b <= viol_b + 1;
        end
        if (frame_done_a) done_a <= done_a + 1;
        if (frame_done_b) done_b <= done_b + 1;
        if (frame_busy_b && !busy_prev_b) starts_b.push_back(cyc);
        busy_prev_b <= frame_busy_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trigger_a();
        @(negedge clk_in);
        trigger_a = 1'b1;
        @(negedge clk_in);
        trigger_a = 1'b0;
    endtask

    task automatic wait_frame_a(input string tag);
        int start;
        start = done_a;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk_in);
            if (done_a != start) break;
        end
        chk(tag, done_a - start, 32'd1);
        repeat (3) @(negedge clk_in);
    endtask

    task automatic check_frame_a(input string tag, input logic [47:0] exp);
        logic [7:0] got;
        chk({tag, "_len"}, q_a.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            got = (k < q_a.size()) ? q_a[k] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, k), {24'h0, got}, {24'h0, exp[47-8*k -: 8]});
        end
        q_a.delete();
    endtask

    initial begin
        int dn;
        reset_n = 1'b0; enable_a = 1'b0; trigger_a = 1'b0; enable_b = 1'b0; trigger_b = 1'b0;
        data_a = 16'h0000; data_b = 32'h0000_0000;
        repeat (3) @(negedge clk_in);
        chk("rst_tx_start", {31'h0, ifa.tx_start}, 32'd0);
        chk("rst_tx_data", {24'h0, ifa.tx_data}, 32'd0);
        chk("rst_frame_busy", {31'h0, frame_busy_a}, 32'd0);
        chk("rst_frame_done", {31'h0, frame_done_a}, 32'd0);
        chk("rst_overrun", {31'h0, overrun_a}, 32'd0);
        reset_n = 1'b1;

        // Basic hex frame: ch0=3C, ch1=A5.
        enable_a = 1'b1;
        data_a   = {8'hA5, 8'h3C};
        pulse_trigger_a();
        wait_frame_a("t1_done");
        check_frame_a("t1", 48'h33_43_20_41_35_0A);
        chk("t1_overrun", {31'h0, overrun_a}, 32'd0);
        chk("t1_idle", {31'h0, frame_busy_a}, 32'd0);

        // Trigger while busy, plus data change mid-frame.
        pulse_trigger_a();
        repeat (4) @(negedge clk_in);
        chk("t4_busy", {31'h0, frame_busy_a}, 32'd1);
        data_a = {8'hEF, 8'hCD};
        pulse_trigger_a();
        wait_frame_a("t4_done");
        check_frame_a("t4", 48'h33_43_20_41_35_0A);
        chk("t4_overrun", {31'h0, overrun_a}, 32'd1);
        dn = done_a;
        repeat (40) @(negedge clk_in);
        chk("t4_no_extra", done_a - dn + q_a.size(), 32'd0);
        pulse_trigger_a();
        wait_frame_a("t5_done");
        check_frame_a("t5", 48'h43_44_20_45_46_0A);
        chk("t5_overrun_sticky", {31'h0, overrun_a}, 32'd1);

        // Remaining hex digits.
        data_a = {8'h23, 8'h01};
        pulse_trigger_a();
        wait_frame_a("hx0_done");
        check_frame_a("hx0", 48'h30_31_20_32_33_0A);
        data_a = {8'h67, 8'h45};
        pulse_trigger_a();
        wait_frame_a("hx1_done");
        check_frame_a("hx1", 48'h34_35_20_36_37_0A);
        data_a = {8'hAB, 8'h89};

        // enable drops mid-frame: frame completes, later triggers ignored.
        pulse_trigger_a();
        repeat (3) @(negedge clk_in);
        enable_a = 1'b0;
        wait_frame_a("en_done");
        check_frame_a("en", 48'h38_39_20_41_42_0A);
        dn = done_a;
        pulse_trigger_a();
        repeat (40) @(negedge clk_in);
        chk("en_ignored", done_a - dn + q_a.size() + {31'h0, frame_busy_a}, 32'd0);

        // Reset mid-frame.
        enable_a = 1'b1;
        pulse_trigger_a();
        for (int i = 0; i < 200 && q_a.size() < 2; i++) @(negedge clk_in);
        chk("rm_progress", {31'h0, frame_busy_a}, 32'd1);
        @(posedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_tx_data", {24'h0, ifa.tx_data}, 32'd0);
        chk("rm_outputs", {28'h0, ifa.tx_start, frame_busy_a, frame_done_a, overrun_a}, 32'd0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        q_a.delete();
        repeat (20) @(negedge clk_in);
        chk("rm_quiet", q_a.size(), 32'd0);
        pulse_trigger_a();
        wait_frame_a("rm_done");
        check_frame_a("rm", 48'h38_39_20_41_42_0A);

        // Periodic raw frames.
        data_b   = {16'hABCD, 16'h1234};
        enable_b = 1'b1;
        for (int i = 0; i < 400 && starts_b.size() < 3; i++) @(negedge clk_in);
        chk("per_count", (starts_b.size() >= 3) ? 32'd3 : starts_b.size(), 32'd3);
        if (starts_b.size() >= 3) begin
            chk("per_gap1", starts_b[1] - starts_b[0], 32'd100);
            chk("per_gap2", starts_b[2] - starts_b[1], 32'd100);
        end
        begin
            logic [47:0] exp_b;
            logic [7:0]  got;
            exp_b = 48'h12_34_20_AB_CD_0A;
            for (int k = 0; k < 6; k++) begin
                got = (k < q_b.size()) ? q_b[k] : 8'hxx;
                chk($sformatf("raw_b%0d", k), {24'h0, got}, {24'h0, exp_b[47-8*k -: 8]});
            end
        end
        chk("per_done", (done_b >= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("per_overrun", {31'h0, overrun_b}, 32'd0);
        chk("start_busy_a", viol_a, 32'd0);
        chk("start_busy_b", viol_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
